// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response encodings and the
// controller FSM state type.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings (anything above word is unsupported here)
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // HRESP codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Controller FSM: one data-phase state per transfer type plus the
    // two-cycle error response.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ctrl_state_t;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_lane_decode.sv
// Combinational byte-lane decoder for 32-bit AHB-Lite slaves: turns
// HSIZE and the low address bits into a lane mask and flags transfers
// the slave cannot honour (oversize or misaligned).
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] lane_mask,
    output logic       illegal
);

    // Illegal transfers always report an empty lane mask so a caller that
    // forgets to gate on illegal still cannot strobe the RAM.
    always_comb begin
        lane_mask = 4'b0000;
        illegal   = 1'b0;
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[0]) begin
                    illegal = 1'b1;
                end else begin
                    lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) begin
                    illegal = 1'b1;
                end else begin
                    lane_mask = 4'b1111;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port block RAM (byte-enabled write
// port A, read-first registered read port B). Zero wait states for reads
// and writes, read-after-write forwarding for back-to-back accesses to the
// same word, and a two-cycle ERROR response for unsupported transfers.
module ahb_bram_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
)
(
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    ctrl_state_t           state_reg;
    ctrl_state_t           state_next;

    logic [3:0]            lane_mask;
    logic                  lane_illegal;
    logic                  addr_phase;
    logic                  legal_rd;
    logic                  legal_wr;
    logic [ADDR_WIDTH-1:0] addr_word;

    logic [ADDR_WIDTH-1:0] addra_reg;
    logic [3:0]            wmask_reg;
    logic [3:0]            fwd_mask_reg;
    logic [31:0]           fwd_data_reg;
    logic                  fwd_hit;
    logic [31:0]           rd_merged;

    // Upper address bits alias onto the RAM; they are intentionally ignored.
    logic                  unused_haddr;
    assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

    ahb_lane_decode u_lane_decode (
        .size      (HSIZE),
        .addr_lo   (HADDR[1:0]),
        .lane_mask (lane_mask),
        .illegal   (lane_illegal)
    );

    // An address phase is only honoured when the bus is ready and we are
    // not in the first (stalling) error cycle.
    assign addr_phase = HSEL & HREADY & trans_active(HTRANS) & (state_reg != ST_ERR1);
    assign legal_rd   = addr_phase & ~lane_illegal & ~HWRITE;
    assign legal_wr   = addr_phase & ~lane_illegal &  HWRITE;
    assign addr_word  = HADDR[ADDR_WIDTH+1:2];

    // The RAM read port is fed straight from the bus so data is ready in
    // the following cycle; write data needs no staging either.
    assign bram_addrb = addr_word;
    assign bram_dina  = HWDATA;
    assign bram_addra = addra_reg;

    // A read landing on the word being written this cycle sees stale data
    // from the read-first RAM and must be patched from the write itself.
    assign fwd_hit = (state_reg == ST_WR) & legal_rd & (addr_word == addra_reg);

    // Per-byte merge of forwarded write data over the RAM output.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_merge
            assign rd_merged[8*gi +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                            : bram_doutb[8*gi +: 8];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: ERR1 always proceeds to ERR2; every other state
    // takes whatever the current address phase asks for.
    always_comb begin
        state_next = ST_IDLE;
        if (state_reg == ST_ERR1) begin
            state_next = ST_ERR2;
        end else if (addr_phase) begin
            if (lane_illegal) begin
                state_next = ST_ERR1;
            end else if (HWRITE) begin
                state_next = ST_WR;
            end else begin
                state_next = ST_RD;
            end
        end
    end

    // Output logic: strobes only in WR, read data only in RD, error
    // signalling in the two ERR states.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'h0000_0000;
        bram_wea  = 4'b0000;
        case (state_reg)
            ST_RD: HRDATA = rd_merged;
            ST_WR: bram_wea = wmask_reg;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // Capture the write address and lane mask during a legal write
    // address phase so they line up with HWDATA in the data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addra_reg <= '0;
            wmask_reg <= 4'b0000;
        end else if (legal_wr) begin
            addra_reg <= addr_word;
            wmask_reg <= lane_mask;
        end
    end

    // Forwarding register: loaded on a same-word read behind a write,
    // consumed by the following RD, dropped on reset.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fwd_mask_reg <= 4'b0000;
            fwd_data_reg <= 32'h0000_0000;
        end else if (fwd_hit) begin
            fwd_mask_reg <= wmask_reg;
            fwd_data_reg <= HWDATA;
        end else if (state_reg == ST_RD) begin
            fwd_mask_reg <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl: a driver issues AHB transfers and
// pushes the expected data-phase response, a negedge monitor pops and
// compares. Expected values come from a byte-level memory model.
module tb_ahb_bram_ctrl;

    localparam int AW    = 12;
    localparam int WORDS = 1 << AW;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;

    always #5 HCLK = ~HCLK;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HREADY     (HREADY),
        .HWDATA     (HWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_addrb (bram_addrb),
        .bram_doutb (bram_doutb)
    );

    // Block RAM environment: byte-enabled write port A, read-first
    // registered read port B.
    logic [31:0] ram [0:WORDS-1];
    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++)
            if (bram_wea[b]) ram[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
        bram_doutb <= ram[bram_addrb];
    end

    // Reference model: memory contents as the bus master should see them.
    logic [31:0] ref_mem [0:WORDS-1];

    typedef struct packed {
        logic [2:0]    tag;    // 0 idle, 1 read, 2 write, 3 err1, 4 err2
        logic          rdy;
        logic          resp;
        logic [31:0]   rdata;
        logic [3:0]    wea;
        logic [AW-1:0] addra;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Pending data phase (accepted in the previous cycle).
    logic [2:0]    cur_tag   = 3'd0;
    logic [AW-1:0] cur_word  = '0;
    logic [3:0]    cur_mask  = 4'b0000;
    logic [31:0]   cur_wdata = 32'h0;

    function automatic string tag_name(input logic [2:0] t);
        case (t)
            3'd1:    return "READ ";
            3'd2:    return "WRITE";
            3'd3:    return "ERR1 ";
            3'd4:    return "ERR2 ";
            default: return "IDLE ";
        endcase
    endfunction

    // Legality: at most a word, naturally aligned to its own size.
    function automatic logic ref_legal(input logic [2:0] sz, input logic [1:0] lo);
        if (sz > 3'd2) return 1'b0;
        return (int'(lo) % (1 << sz)) == 0;
    endfunction

    // Lanes covered by a legal transfer: bytes lo .. lo+size-1.
    function automatic logic [3:0] ref_lanes(input logic [2:0] sz, input logic [1:0] lo);
        logic [3:0] m;
        int         n;
        m = 4'b0000;
        n = 1 << sz;
        for (int b = 0; b < 4; b++)
            if (b >= int'(lo) && b < int'(lo) + n) m[b] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // One bus cycle: drive the data phase of the pending transfer plus a
    // new address phase, and queue the expected response for this cycle.
    task automatic bus_cycle(input logic sel, input logic rdy, input logic [1:0] trans,
                             input logic [2:0] size, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic rdy_eff;
        @(posedge HCLK);
        #1;
        e = '{tag: cur_tag, rdy: 1'b1, resp: 1'b0, rdata: 32'h0, wea: 4'b0000, addra: '0};
        rdy_eff = rdy;
        HWDATA  = $urandom;
        case (cur_tag)
            3'd1: begin
                e.rdata = ref_mem[cur_word];
                rdy_eff = 1'b1;
            end
            3'd2: begin
                HWDATA  = cur_wdata;
                e.wea   = cur_mask;
                e.addra = cur_word;
                for (int b = 0; b < 4; b++)
                    if (cur_mask[b]) ref_mem[cur_word][8*b +: 8] = cur_wdata[8*b +: 8];
                rdy_eff = 1'b1;
            end
            3'd3: begin
                e.rdy   = 1'b0;
                e.resp  = 1'b1;
                rdy_eff = 1'b0;
            end
            3'd4: begin
                e.resp  = 1'b1;
                rdy_eff = 1'b1;
            end
            default: ;
        endcase
        HSEL   = sel;
        HREADY = rdy_eff;
        HTRANS = trans;
        HSIZE  = size;
        HWRITE = wr;
        HADDR  = addr;
        exp_q.push_back(e);
        if (cur_tag == 3'd3) begin
            cur_tag = 3'd4;
        end else if (sel && rdy_eff && trans[1]) begin
            if (!ref_legal(size, addr[1:0])) begin
                cur_tag = 3'd3;
            end else begin
                cur_tag   = wr ? 3'd2 : 3'd1;
                cur_word  = addr[AW+1:2];
                cur_mask  = ref_lanes(size, addr[1:0]);
                cur_wdata = wdata;
            end
        end else begin
            cur_tag = 3'd0;
        end
    endtask

    task automatic wr_x(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
        bus_cycle(1'b1, 1'b1, 2'b10, size, 1'b1, addr, d);
    endtask

    task automatic rd_x(input logic [2:0] size, input logic [31:0] addr);
        bus_cycle(1'b1, 1'b1, 2'b10, size, 1'b0, addr, 32'h0);
    endtask

    task automatic idle_x();
        bus_cycle(1'b0, 1'b1, 2'b00, 3'd2, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, " HREADYOUT"}, {31'h0, HREADYOUT}, 32'h1);
        chk({where, " HRESP"},     {31'h0, HRESP},     32'h0);
        chk({where, " HRDATA"},    HRDATA,             32'h0);
        chk({where, " bram_wea"},  {28'h0, bram_wea},  32'h0);
        chk({where, " bram_addra"}, {{(32-AW){1'b0}}, bram_addra}, 32'h0);
    endtask

    // Monitor: pop the expectation for each driven cycle and compare.
    always @(negedge HCLK) begin
        exp_t e;
        logic ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (HREADYOUT === e.rdy) && (HRESP === e.resp) && (HRDATA === e.rdata) &&
                 (bram_wea === e.wea) && ((e.wea == 4'b0000) || (bram_addra === e.addra));
            n_checks++;
            if (ok) begin
                n_pass++;
                if (e.tag != 3'd0)
                    $display("%0t %s rdy=%b resp=%b rdata=%h wea=%b addra=%h ok",
                             $time, tag_name(e.tag), HREADYOUT, HRESP, HRDATA, bram_wea, bram_addra);
            end else begin
                $display("FAIL %s @%0t: got rdy=%b resp=%b rdata=%h wea=%b addra=%h, required rdy=%b resp=%b rdata=%h wea=%b addra=%h",
                         tag_name(e.tag), $time, HREADYOUT, HRESP, HRDATA, bram_wea, bram_addra,
                         e.rdy, e.resp, e.rdata, e.wea, e.addra);
            end
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i]     = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HTRANS = 2'b00;
        HSIZE  = 3'd0;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs("reset");
        HRESET = 1'b0;

        // Word write then read two cycles later.
        wr_x(3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        idle_x();
        rd_x(3'd2, 32'h0000_0010);
        idle_x();

        // Byte write over a known word.
        wr_x(3'd2, 32'h0000_0010, 32'h1122_3344);
        idle_x();
        wr_x(3'd0, 32'h0000_0013, 32'hAA5A_5A5A);
        idle_x();
        rd_x(3'd2, 32'h0000_0010);
        idle_x();

        // Back-to-back write/read to the same word (forwarding).
        wr_x(3'd2, 32'h0000_0020, 32'h5566_7788);
        rd_x(3'd2, 32'h0000_0020);
        idle_x();
        wr_x(3'd2, 32'h0000_0020, 32'h1122_3344);
        idle_x();
        wr_x(3'd1, 32'h0000_0022, 32'hBEEF_1234);
        rd_x(3'd2, 32'h0000_0020);
        idle_x();

        // Illegal transfers: misaligned word, misaligned halfword, oversize.
        wr_x(3'd2, 32'h0000_0002, 32'hFFFF_FFFF);
        idle_x();
        idle_x();
        rd_x(3'd1, 32'h0000_0001);
        idle_x();
        idle_x();
        wr_x(3'd3, 32'h0000_0000, 32'hFFFF_FFFF);
        idle_x();
        rd_x(3'd2, 32'h0000_0000);   // accepted in ERR2
        idle_x();

        // IDLE/BUSY and deselected writes must not touch memory.
        bus_cycle(1'b1, 1'b1, 2'b00, 3'd2, 1'b1, 32'h0000_0010, 32'h0);
        bus_cycle(1'b0, 1'b1, 2'b10, 3'd2, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
        bus_cycle(1'b1, 1'b1, 2'b01, 3'd2, 1'b1, 32'h0000_0010, 32'h0);
        bus_cycle(1'b1, 1'b0, 2'b10, 3'd2, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
        rd_x(3'd2, 32'h0000_0010);
        idle_x();

        // Reset during the WR data phase drops the write.
        wr_x(3'd2, 32'h0000_0030, 32'hCAFE_F00D);
        idle_x();
        wr_x(3'd2, 32'h0000_0030, 32'h0BAD_BEEF);
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = cur_wdata;
        HRESET = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge HCLK);
        #1;
        HRESET  = 1'b0;
        cur_tag = 3'd0;
        idle_x();
        rd_x(3'd2, 32'h0000_0030);
        idle_x();

        // Randomized traffic over a small window plus the top word, with
        // aliased upper address bits.
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            int          w;
            w  = ($urandom_range(0, 9) == 0) ? (WORDS - 1) : int'($urandom_range(0, 15));
            a  = ($urandom & 32'hFFFF_C000) | 32'(w << 2) | 32'($urandom_range(0, 3));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            bus_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                      2'($urandom_range(0, 3)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        repeat (3) idle_x();
        @(posedge HCLK);
        @(posedge HCLK);
        chk("queue drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave that drives the SoC's dual-port block RAM (byte-enabled write port A, one-cycle registered read port B) from the Cortex-M0 bus. Sits between the AHB decoder/mux and the RAM instance. Provides zero-wait-state reads and writes, byte/halfword/word lane strobes, read-after-write forwarding, and a two-cycle ERROR response for illegal transfers.

## Interface
- ADDR_WIDTH, 12, RAM word-address width; RAM size is 4·2^ADDR_WIDTH bytes.
- HCLK  in  1  single clock for bus and RAM.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only bits [ADDR_WIDTH+1:0] are used, so upper bits alias.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; larger sizes are illegal.
- HWRITE  in  1  1=write.
- HREADY  in  1  bus-wide ready, used to qualify the address phase.
- HWDATA  in  32  write data in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- bram_addra  out  ADDR_WIDTH  write word address (registered).
- bram_dina  out  32  write data; passthrough of HWDATA.
- bram_wea  out  4  byte write strobes.
- bram_addrb  out  ADDR_WIDTH  read word address; combinational from HADDR[ADDR_WIDTH+1:2].
- bram_doutb  in  32  RAM read data, valid the cycle after bram_addrb is presented.

## Operation
- An address phase is accepted when HSEL & HREADY & HTRANS[1]. IDLE and BUSY transfers get OKAY with no RAM access.
- Lane decode: byte → one lane at HADDR[1:0]; halfword → lanes {1,0} or {3,2} by HADDR[1]; word → all four lanes.
- Illegal transfer: HSIZE > 010, halfword with HADDR[0]=1, or word with HADDR[1:0]≠00. An illegal transfer never touches the RAM and gets an ERROR response.
- FSM states and transitions:
  - IDLE: accepted legal read → RD; accepted legal write → WR; accepted illegal → ERR1.
  - RD / WR: each is a one-cycle data phase with HREADYOUT=1. The next state follows the same acceptance rule as IDLE; if nothing is accepted, the FSM returns to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the acceptance rule.
- Write: the address phase registers the word address into bram_addra and the lane mask internally. In WR, bram_wea = lane mask; otherwise bram_wea = 0000. The RAM commits at the clock edge that ends WR.
- Read: the RAM samples bram_addrb at the edge that ends the address phase. In RD, HRDATA is built from bram_doutb.
- Forwarding: a read accepted during WR to the same word index returns stale data from the read-first RAM. On that edge, register fwd_mask = the WR lane mask and fwd_data = HWDATA. In the following RD, each byte i of HRDATA = fwd_mask[i] ? fwd_data byte i : bram_doutb byte i. fwd_mask clears after RD.
- HRDATA = 0 outside RD.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, bram_wea=0000, bram_addra=0, FSM=IDLE, fwd_mask=0000.
- Read latency: data is valid in the cycle after the address phase (zero wait states).
- Write: strobes are asserted in the data phase (zero wait states).
- Error response: exactly two cycles (ERR1, ERR2).
- Back-to-back transfers: sustained at one per cycle for any mix of reads and writes.
- Reset mid-operation: asserting HRESET during WR forces bram_wea=0000 immediately, so the write is dropped. A pending forward is discarded.
- Out-of-range address: the word index wraps modulo 2^ADDR_WIDTH.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS and HSIZE encodings
  - HRESP codes
  - FSM state encoding (IDLE, RD, WR, ERR1, ERR2)
- Sub-module ahb_lane_decode: combinational HSIZE/HADDR[1:0] → 4-bit lane mask plus misaligned/illegal flag. It is reused by future AHB peripherals.

## Test plan
- Word write 0xDEADBEEF to 0x0000_0010, then word read of 0x10 two cycles later → bram_wea=1111 at addra=4; HRDATA=0xDEADBEEF one cycle after the read address phase, OKAY.
- Byte write 0xAA to 0x13 over prior 0x11223344 → bram_wea=1000; later word read = 0xAA223344.
- Back-to-back write (word 0x5566_7788 @0x20) immediately followed by a read of 0x20 → HRDATA=0x55667788 via forwarding. Repeat with halfword write 0xBEEF @0x22 over 0x11223344 → 0xBEEF3344.
- Word access at 0x02, halfword at 0x01, HSIZE=011 → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); bram_wea stays 0000 throughout.
- IDLE/BUSY transfers interleaved with HSEL=0 writes → bram_wea=0000, OKAY, no change to memory.
- HRESET pulsed during the WR data phase of a write to 0x30 → no strobe; a subsequent read of 0x30 returns the old value; all outputs show their reset values while HRESET is high.
